debug_dump_seq: RTL and testbench
=================================

Name: debug_dump_seq

Overview:
Post-halt dump sequencer for the debug path. On a start pulse it walks a fixed list of words and streams each one over the UART TX handshake as 4 bytes:
- program counter
- cycle count
- register bank R0..R31
- data memory words 0..127
It owns the register-bank and data-memory debug read ports for the duration of the dump and sits between the pipeline/memories and the debug UART transmitter.

Parameters:
NB_DATA, 32, width of every dumped word
NB_BYTE, 8, UART byte width
NB_REG, 5, register address width
N_REGS, 32, number of registers dumped
NB_MEM_ADDR, 7, data memory address width
N_MEM, 128, number of memory words dumped

Ports:
i_clock  in  1  single system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle request to begin a dump (issued after halt)
i_pc  in  NB_DATA  program counter to report
i_cycles  in  NB_DATA  executed-cycle count to report
i_reg_data  in  NB_DATA  register bank read data, 1-cycle synchronous latency
i_mem_data  in  NB_DATA  data memory read data, 1-cycle synchronous latency
i_tx_done  in  1  UART TX byte-complete pulse
o_reg_addr  out  NB_REG  register read address
o_reg_rd  out  1  register debug-read enable (selects debug port in bank)
o_mem_addr  out  NB_MEM_ADDR  memory read address
o_mem_rd  out  1  memory debug-read enable
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_start  out  1  one-cycle TX start pulse
o_busy  out  1  high from the cycle after accepted i_start until DONE
o_done  out  1  one-cycle pulse when the last byte's i_tx_done is seen

Behaviour:
- Reset (async, i_reset=0): state IDLE, all outputs 0, word index 0, byte index 0. Reset mid-dump aborts immediately; no resume.
- Word order: index 0 = i_pc, 1 = i_cycles, 2..33 = R0..R31, 34..161 = MEM[0..127]. Total 162 words, 648 bytes.
- Byte order within a word: MSB first (bits 31:24, 23:16, 15:8, 7:0).
- States:
  - IDLE: i_start=1 -> SEL. i_start while not IDLE is ignored.
  - SEL: drive o_reg_addr/o_reg_rd or o_mem_addr/o_mem_rd for the current index. PC and cycle words need no read. -> WAIT_RD.
  - WAIT_RD: one cycle for read latency. -> LATCH.
  - LATCH: capture the word into a 32-bit shift register; byte index 0. -> SEND.
  - SEND: o_tx_data = top byte; o_tx_start=1 for exactly this cycle. -> WAIT_TX.
  - WAIT_TX: hold o_tx_data stable. On i_tx_done:
    - byte index < 3: shift left 8, increment byte index -> SEND.
    - byte index = 3, last word: -> DONE.
    - byte index = 3, otherwise: increment word index -> SEL.
  - DONE: o_done=1 for one cycle, o_busy=0, read enables 0. -> IDLE.
- i_tx_done outside WAIT_TX is ignored. i_tx_done in the same cycle as SEND is ignored; only WAIT_TX samples it.
- Read enables are held high from the SEL to LATCH cycles of their word and are 0 otherwise. Addresses hold their last value while idle.
- Inputs i_pc and i_cycles are sampled in their own LATCH cycle.
- Register index wraps 31 -> memory phase. Memory index 127 is last; no wrap beyond it.
- Minimum time per word: 3 cycles plus 4 TX handshakes.

Optional Feature:
Macro DUMP_DIRTY_EN.
- Defined: adds port i_mem_dirty (in, 1, dirty bit of the addressed memory word, same latency as i_mem_data).
  - In LATCH of a memory word, dirty=0 skips the word entirely: no bytes, next index.
  - Dirty words are sent as 5 bytes: address byte {1'b0, addr[6:0]} first, then 4 data bytes MSB first.
  - If MEM[127] is skipped, DONE follows directly.
- Undefined: port absent; all 128 memory words are sent as 4 bytes each.

Test Plan:
1. Reset low mid-dump (word 40, byte 2) -> next cycle o_busy=0, o_tx_start=0, all addresses 0; a new i_start restarts at the PC word.
2. i_pc=0x00000003, i_cycles=0x00000004, i_start pulse, TX model returns i_tx_done 10 cycles after each start -> first 8 bytes are 00,00,00,03,00,00,00,04.
3. Register bank Rn=n, memory word k = 0xA5000000+k, full dump -> 648 bytes; byte 8..11 = 00,00,00,00; last 4 bytes = A5,00,00,7F; o_done pulses once.
4. Check read control -> o_reg_addr steps 0..31 then o_mem_addr steps 0..127; o_reg_rd/o_mem_rd never high together; each read enable is high 3 cycles per word.
5. Second i_start and spurious i_tx_done pulses injected during SEND and mid-dump -> byte stream and count (648) unchanged.
6. With DUMP_DIRTY_EN defined, only MEM[5] and MEM[127] dirty -> 34*4 + 2*5 = 146 bytes; the memory part is 05,A5,00,00,05,7F,A5,00,00,7F.

Source files
------------

// File: rtl/debug_dump_seq.sv
// debug_dump_seq: post-halt sequencer streaming PC, cycle count, R0..R31 and MEM[0..127] MSB-first over UART TX.
// Optional macro DUMP_DIRTY_EN: clean memory words are skipped, dirty ones go out prefixed with their address byte.
module debug_dump_seq #(
    parameter int NB_DATA     = 32,
    parameter int NB_BYTE     = 8,
    parameter int NB_REG      = 5,
    parameter int N_REGS      = 32,
    parameter int NB_MEM_ADDR = 7,
    parameter int N_MEM       = 128
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycles,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
`ifdef DUMP_DIRTY_EN
    input  logic                   i_mem_dirty,
`endif
    input  logic                   i_tx_done,
    output logic [NB_REG-1:0]      o_reg_addr,
    output logic                   o_reg_rd,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    output logic                   o_mem_rd,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_done
);
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT_RD, S_LATCH, S_SEND, S_WAIT_TX, S_DONE} state_t;
    typedef enum logic [1:0] {P_PC, P_CYC, P_REG, P_MEM} phase_t;
`ifdef DUMP_DIRTY_EN
    localparam int NB_SH = NB_DATA + NB_BYTE;
`else
    localparam int NB_SH = NB_DATA;
`endif
    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d, phase_nx;
    logic [NB_REG-1:0]      reg_addr_q, reg_addr_d, reg_addr_nx;
    logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d, mem_addr_nx;
    logic [NB_SH-1:0]       shift_q, shift_d;
    logic [2:0]             byte_q, byte_d, last_byte;
    logic [NB_DATA-1:0]     word;
    logic                   reg_last, last_word, rd_win;
    logic                   reg_rd_q, reg_rd_d, mem_rd_q, mem_rd_d;
    logic                   tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        word        = phase_q == P_PC ? i_pc : phase_q == P_CYC ? i_cycles : phase_q == P_REG ? i_reg_data : i_mem_data;
        reg_last    = reg_addr_q == NB_REG'(N_REGS - 1);
        last_word   = phase_q == P_MEM && mem_addr_q == NB_MEM_ADDR'(N_MEM - 1);
        phase_nx    = phase_q == P_PC ? P_CYC : phase_q == P_CYC ? P_REG : (phase_q == P_REG && reg_last) ? P_MEM : phase_q;
        reg_addr_nx = (phase_q == P_REG && !reg_last) ? reg_addr_q + 1'b1 : reg_addr_q;
        mem_addr_nx = (phase_q == P_MEM && !last_word) ? mem_addr_q + 1'b1 : mem_addr_q;
`ifdef DUMP_DIRTY_EN
        last_byte   = phase_q == P_MEM ? 3'd4 : 3'd3;
`else
        last_byte   = 3'd3;
`endif
        state_d     = state_q;
        phase_d     = phase_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d    = S_SEL;
                phase_d    = P_PC;
                reg_addr_d = '0;
                mem_addr_d = '0;
            end
            S_SEL:     state_d = S_WAIT_RD;
            S_WAIT_RD: state_d = S_LATCH;
            S_LATCH: begin
                byte_d  = '0;
                state_d = S_SEND;
`ifdef DUMP_DIRTY_EN
                shift_d = phase_q == P_MEM ? {NB_BYTE'(mem_addr_q), word} : {word, NB_BYTE'(0)};
                if (phase_q == P_MEM && !i_mem_dirty) begin
                    state_d    = last_word ? S_DONE : S_SEL;
                    mem_addr_d = mem_addr_nx;
                end
`else
                shift_d = word;
`endif
            end
            S_SEND:    state_d = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) begin
                if (byte_q != last_byte) begin
                    shift_d = shift_q << NB_BYTE;
                    byte_d  = byte_q + 1'b1;
                    state_d = S_SEND;
                end else if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_SEL;
                    phase_d    = phase_nx;
                    reg_addr_d = reg_addr_nx;
                    mem_addr_d = mem_addr_nx;
                end
            end
            default:   state_d = S_IDLE;
        endcase
        // outputs are decoded from the next state so they line up with the state they belong to
        rd_win     = state_d == S_SEL || state_d == S_WAIT_RD || state_d == S_LATCH;
        reg_rd_d   = rd_win && phase_d == P_REG;
        mem_rd_d   = rd_win && phase_d == P_MEM;
        tx_start_d = state_d == S_SEND;
        busy_d     = state_d != S_IDLE && state_d != S_DONE;
        done_d     = state_d == S_DONE;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            phase_q    <= P_PC;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            reg_rd_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            reg_rd_q   <= reg_rd_d;
            mem_rd_q   <= mem_rd_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_reg_addr = reg_addr_q;
    assign o_reg_rd   = reg_rd_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_rd   = mem_rd_q;
    assign o_tx_data  = shift_q[NB_SH-1 -: NB_BYTE];
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
endmodule

// File: tb/tb_debug_dump_seq.sv
// tb_debug_dump_seq: scoreboarded directed bench for debug_dump_seq with register/memory/UART models.
// Builds with or without DUMP_DIRTY_EN; the expected stream follows the build.
module tb_debug_dump_seq;
`ifdef DUMP_DIRTY_EN
    localparam int TOTAL = 146;
    localparam int ABORT = 138;
`else
    localparam int TOTAL = 648;
    localparam int ABORT = 162;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, model_done = 1'b0, spur = 1'b0;
    logic        tx_done;
    logic [31:0] pc = 32'h0, cyc = 32'h0, reg_data = 32'h0, mem_data = 32'h0;
    logic [4:0]  reg_addr;
    logic [6:0]  mem_addr;
    logic [7:0]  tx_data;
    logic        reg_rd, mem_rd, tx_start, busy, done;
`ifdef DUMP_DIRTY_EN
    logic        dirty = 1'b0;
`endif
    int          vectors = 0, errs = 0;
    logic [7:0]  expq[$];
    logic [7:0]  rx[$];
    int          tx_cnt = 0, done_cnt = 0, exp_reg = 0, exp_mem = 0, reg_run = 0, mem_run = 0;
    logic        reg_rd_p = 1'b0, mem_rd_p = 1'b0;

    assign tx_done = model_done | spur;
    always #5 clk = ~clk;

    debug_dump_seq dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_pc(pc), .i_cycles(cyc),
        .i_reg_data(reg_data), .i_mem_data(mem_data),
`ifdef DUMP_DIRTY_EN
        .i_mem_dirty(dirty),
`endif
        .i_tx_done(tx_done), .o_reg_addr(reg_addr), .o_reg_rd(reg_rd), .o_mem_addr(mem_addr),
        .o_mem_rd(mem_rd), .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_done(done)
    );

    // register bank Rn = n, memory word k = 0xA5000000 + k, both with one cycle of read latency
    always @(posedge clk) begin
        reg_data <= {27'd0, reg_addr};
        mem_data <= 32'hA500_0000 + {25'd0, mem_addr};
`ifdef DUMP_DIRTY_EN
        dirty    <= mem_addr == 7'd5 || mem_addr == 7'd127;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model answers each start 10 cycles later; scoreboard pops on every start
    always @(negedge clk) begin
        model_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) model_done = 1'b1;
        end
        if (tx_start) begin
            rx.push_back(tx_data);
            if (expq.size() == 0) check("tx_overrun", 32'(expq.size()), 32'd1);
            else check("tx_byte", {24'd0, tx_data}, {24'd0, expq.pop_front()});
            tx_cnt = 10;
        end
        if (done) done_cnt++;
        check("rd_exclusive", {31'd0, reg_rd & mem_rd}, 32'd0);
        if (reg_rd && !reg_rd_p) begin
            check("reg_addr", {27'd0, reg_addr}, 32'(exp_reg));
            exp_reg++;
        end
        if (reg_rd) reg_run++;
        else if (reg_rd_p) begin
            check("reg_rd_len", 32'(reg_run), 32'd3);
            reg_run = 0;
        end
`ifndef DUMP_DIRTY_EN
        if (mem_rd && !mem_rd_p) begin
            check("mem_addr", {25'd0, mem_addr}, 32'(exp_mem));
            exp_mem++;
        end
        if (mem_rd) mem_run++;
        else if (mem_rd_p) begin
            check("mem_rd_len", 32'(mem_run), 32'd3);
            mem_run = 0;
        end
`endif
        reg_rd_p = reg_rd;
        mem_rd_p = mem_rd;
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) expq.push_back(w[i*8 +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] p, input logic [31:0] c);
        push_word(p);
        push_word(c);
        for (int r = 0; r < 32; r++) push_word(32'(r));
        for (int k = 0; k < 128; k++) begin
`ifdef DUMP_DIRTY_EN
            if (k == 5 || k == 127) begin
                expq.push_back(8'(k));
                push_word(32'hA500_0000 + 32'(k));
            end
`else
            push_word(32'hA500_0000 + 32'(k));
`endif
        end
    endtask

    task automatic start_dump();
        @(negedge clk);
        expq.delete();
        rx.delete();
        tx_cnt = 0; model_done = 1'b0; done_cnt = 0;
        exp_reg = 0; exp_mem = 0; reg_run = 0; mem_run = 0;
        push_dump(pc, cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_dump();
        int n = 0;
        while (!done && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, n < 12000}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("byte_count", 32'(rx.size()), 32'(TOTAL));
        check("sb_empty", 32'(expq.size()), 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("reg_words", 32'(exp_reg), 32'd32);
`ifndef DUMP_DIRTY_EN
        check("mem_words", 32'(exp_mem), 32'd128);
`endif
    endtask

    task automatic wait_sig(input string tag, input bit want_rd);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(want_rd ? reg_rd : tx_start) && n < 2000);
        check(tag, {31'd0, n < 2000}, 32'd1);
    endtask

    task automatic spurious_pulse();
        spur = 1'b1;
        start = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] head[12] = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef DUMP_DIRTY_EN
        logic [7:0] tail[10] = '{8'h05, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h7F};
`else
        logic [7:0] tail[4] = '{8'hA5, 8'h00, 8'h00, 8'h7F};
`endif
        int n;
        pc = 32'h0000_0003;
        cyc = 32'h0000_0004;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_rd", {30'd0, reg_rd, mem_rd}, 32'd0);
        check("rst_addr", {20'd0, reg_addr, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // abort in the middle of a memory word, then restart from the PC word
        start_dump();
        n = 0;
        while (rx.size() < ABORT + 1 && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach", {31'd0, n < 10000}, 32'd1);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_start", {31'd0, tx_start}, 32'd0);
        check("abort_reg_addr", {27'd0, reg_addr}, 32'd0);
        check("abort_mem_addr", {25'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_dump();
        check("busy_started", {31'd0, busy}, 32'd1);
        finish_dump();
        for (int i = 0; i < 12; i++) check($sformatf("head%0d", i), {24'd0, rx[i]}, {24'd0, head[i]});
`ifdef DUMP_DIRTY_EN
        for (int i = 0; i < 10; i++) check($sformatf("mem_part%0d", i), {24'd0, rx[136 + i]}, {24'd0, tail[i]});
`else
        for (int i = 0; i < 4; i++) check($sformatf("tail%0d", i), {24'd0, rx[644 + i]}, {24'd0, tail[i]});
`endif

        // spurious i_start / i_tx_done during SEND and during register reads must change nothing
        pc = 32'hDEAD_BEEF;
        cyc = 32'h1234_5678;
        start_dump();
        for (int k = 0; k < 4; k++) begin
            wait_sig("wait_send", 1'b0);
            spurious_pulse();
            wait_sig("wait_reg_rd", 1'b1);
            spurious_pulse();
        end
        finish_dump();
        check("spur_head0", {24'd0, rx[0]}, 32'hDE);
        check("spur_head7", {24'd0, rx[7]}, 32'h78);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
